exe_unit_w2: RTL and testbench

Second-generation parametrised execution unit for the datapath. It takes M-bit signed operands and a 3-bit opcode and produces a registered M-bit result with a 2-bit status code. It covers compare, sign-magnitude to U2 conversion, saturating add/sub and an optional multi-cycle saturating multiply, all behind a valid/ready handshake. It sits between operand fetch and the writeback register, replacing the purely combinational first-generation unit.

---
 rtl/exe_pkg.sv | 48 ++++
 rtl/exe_mul_seq.sv | 69 ++++++
 rtl/exe_unit_w2.sv | 226 ++++++++++++++++++++++
 tb/tb_exe_unit_w2.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exe_pkg
// Description : Shared types for the exe_unit_w2 execution unit: opcode,
//               status and FSM state encodings, plus the status priority
//               encoder used by both the single-cycle and multiply paths.
// Revision    : 1.0 - initial release
// ============================================================================
package exe_pkg;

    localparam int c_OP_W     = 3;
    localparam int c_STATUS_W = 2;

    typedef enum logic [2:0] {
        OP_CMP   = 3'b000,
        OP_SM2U2 = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_MUL   = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_ZERO = 2'b01,
        ST_SAT  = 2'b10,
        ST_ILL  = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Priority: illegal > saturated > zero > ok.
    function automatic status_e status_of(input logic ill, input logic sat, input logic zero);
        if (ill) begin
            return ST_ILL;
        end else if (sat) begin
            return ST_SAT;
        end else if (zero) begin
            return ST_ZERO;
        end
        return ST_OK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exe_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : exe_mul_seq
// Description : Unsigned shift-add multiplier. One multiplier bit is consumed
//               per cycle; M cycles after i_start the full 2M-bit product is
//               on o_product and o_done stays high until the next start.
// Ports       : clk, rst (sync, active-high)
//               i_start        load operands and begin
//               i_mag_a/i_mag_b M-bit unsigned magnitudes
//               o_product      2M-bit product
//               o_done         product valid
// Revision    : 1.0 - initial release
// ============================================================================
module exe_mul_seq #(
    parameter int M = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [M-1:0]   i_mag_a,
    input  logic [M-1:0]   i_mag_b,
    output logic [2*M-1:0] o_product,
    output logic           o_done
);

    localparam int c_CNT_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(M - 1);

    logic [2*M-1:0]   r_acc;
    logic [2*M-1:0]   r_mcand;
    logic [M-1:0]     r_mplier;
    logic [c_CNT_W-1:0] r_step;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_step   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{M{1'b0}}, i_mag_a};
            r_mplier <= i_mag_b;
            r_step   <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_step   <= r_step + 1'b1;
            if (r_step == c_LAST) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign o_product = r_acc;
    assign o_done    = r_done;

endmodule
`default_nettype wire

// File: rtl/exe_unit_w2.sv
`default_nettype none
// ============================================================================
// Module      : exe_unit_w2
// Description : Registered execution unit with valid/ready handshake.
//               Ops: CMP, SM2U2, saturating ADD/SUB (1-cycle) and an
//               optional multi-cycle saturating MUL.
// Config      : EXE_UNIT_W2_MUL_EN - when defined, MUL is built (IDLE/BUSY/
//               DONE FSM + exe_mul_seq). When undefined, opcode 100 is
//               illegal and o_ready is constantly 1.
// Ports       : i_clk, i_rsn (sync, active-high reset)
//               i_valid/o_ready  input handshake
//               i_oper, i_argA, i_argB  opcode and operands
//               o_valid  1-cycle result strobe
//               o_result/o_status  registered result and status code
// Revision    : 1.0 - initial release
// ============================================================================
module exe_unit_w2
    import exe_pkg::*;
#(
    parameter int M = 8
) (
    input  logic         i_clk,
    input  logic         i_rsn,
    input  logic         i_valid,
    input  logic [2:0]   i_oper,
    input  logic [M-1:0] i_argA,
    input  logic [M-1:0] i_argB,
    output logic         o_ready,
    output logic         o_valid,
    output logic [M-1:0] o_result,
    output logic [1:0]   o_status
);

    localparam logic [M-1:0] c_MAX = {1'b0, {(M-1){1'b1}}};
    localparam logic [M-1:0] c_MIN = {1'b1, {(M-1){1'b0}}};

    logic         r_valid;
    logic [M-1:0] r_result;
    logic [1:0]   r_status;

    // ---------------------------------------------------------------------
    // Single-cycle operations
    // ---------------------------------------------------------------------
    logic [M:0]   w_sum;
    logic [M:0]   w_dif;
    logic [M-1:0] w_sm_mag;
    logic [M-1:0] w_res;
    logic         w_sat;
    logic         w_ill;
    status_e      w_stat;

    // One guard bit: overflow shows as the top two bits disagreeing.
    assign w_sum    = {i_argA[M-1], i_argA} + {i_argB[M-1], i_argB};
    assign w_dif    = {i_argA[M-1], i_argA} - {i_argB[M-1], i_argB};
    assign w_sm_mag = {1'b0, i_argA[M-2:0]};

    always_comb begin
        w_res = '0;
        w_sat = 1'b0;
        w_ill = 1'b0;
        case (i_oper)
            OP_CMP: begin
                w_res = ($signed(i_argA) < $signed(i_argB)) ? c_MAX : '0;
            end
            OP_SM2U2: begin
                // Negative zero naturally maps to 0.
                w_res = i_argA[M-1] ? -w_sm_mag : w_sm_mag;
            end
            OP_ADD: begin
                if (w_sum[M] != w_sum[M-1]) begin
                    w_sat = 1'b1;
                    w_res = w_sum[M] ? c_MIN : c_MAX;
                end else begin
                    w_res = w_sum[M-1:0];
                end
            end
            OP_SUB: begin
                if (w_dif[M] != w_dif[M-1]) begin
                    w_sat = 1'b1;
                    w_res = w_dif[M] ? c_MIN : c_MAX;
                end else begin
                    w_res = w_dif[M-1:0];
                end
            end
            default: begin
                // MUL never reaches this path when it is built; the FSM
                // diverts it first.
                w_ill = 1'b1;
            end
        endcase
        w_stat = status_of(w_ill, w_sat, (w_res == '0));
    end

`ifdef EXE_UNIT_W2_MUL_EN
    // ---------------------------------------------------------------------
    // Multi-cycle multiply
    // ---------------------------------------------------------------------
    localparam int c_CNT_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(M - 1);
    // Largest magnitudes that still fit in M signed bits.
    localparam logic [2*M-1:0] c_POS_LIM = {{(M+1){1'b0}}, {(M-1){1'b1}}};
    localparam logic [2*M-1:0] c_NEG_LIM = {{M{1'b0}}, 1'b1, {(M-1){1'b0}}};

    state_e             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_neg;

    logic [M-1:0]       w_mag_a;
    logic [M-1:0]       w_mag_b;
    logic               w_mul_start;
    logic [2*M-1:0]     w_prod;
    logic               w_mul_done;
    logic [M-1:0]       w_mres;
    logic               w_msat;
    status_e            w_mstat;

    // Magnitude of -2^(M-1) is 2^(M-1), which still fits M unsigned bits.
    assign w_mag_a     = i_argA[M-1] ? -i_argA : i_argA;
    assign w_mag_b     = i_argB[M-1] ? -i_argB : i_argB;
    assign w_mul_start = (r_state == S_IDLE) && i_valid && (i_oper == OP_MUL);

    exe_mul_seq #(
        .M (M)
    ) u_mul (
        .clk       (i_clk),
        .rst       (i_rsn),
        .i_start   (w_mul_start),
        .i_mag_a   (w_mag_a),
        .i_mag_b   (w_mag_b),
        .o_product (w_prod),
        .o_done    (w_mul_done)
    );

    always_comb begin
        w_mres = '0;
        w_msat = 1'b0;
        if (r_neg) begin
            if (w_prod > c_NEG_LIM) begin
                w_msat = 1'b1;
                w_mres = c_MIN;
            end else begin
                w_mres = -w_prod[M-1:0];
            end
        end else begin
            if (w_prod > c_POS_LIM) begin
                w_msat = 1'b1;
                w_mres = c_MAX;
            end else begin
                w_mres = w_prod[M-1:0];
            end
        end
        w_mstat = status_of(1'b0, w_msat, (w_mres == '0));
    end

    always_ff @(posedge i_clk) begin
        if (i_rsn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_status <= ST_OK;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        if (i_oper == OP_MUL) begin
                            r_state <= S_BUSY;
                            r_cnt   <= '0;
                            r_neg   <= i_argA[M-1] ^ i_argB[M-1];
                        end else begin
                            r_result <= w_res;
                            r_status <= w_stat;
                            r_valid  <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // The multiplier finishes on the same edge the FSM
                    // enters DONE, so the product is ready here.
                    if (w_mul_done) begin
                        r_result <= w_mres;
                        r_status <= w_mstat;
                        r_valid  <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready = (r_state == S_IDLE);
`else
    always_ff @(posedge i_clk) begin
        if (i_rsn) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_status <= ST_OK;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_result <= w_res;
                r_status <= w_stat;
            end
        end
    end

    assign o_ready = 1'b1;
`endif

    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_status = r_status;

endmodule
`default_nettype wire

// File: tb/tb_exe_unit_w2.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_unit_w2
// Description : Scoreboard bench for exe_unit_w2 at M=8. Expectations come
//               from an integer reference model and are queued on accept;
//               the monitor checks value, status and arrival cycle.
//               Honours EXE_UNIT_W2_MUL_EN for the expected MUL behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_unit_w2;
    import exe_pkg::*;

`ifdef EXE_UNIT_W2_MUL_EN
    localparam bit c_MUL_EN = 1'b1;
`else
    localparam bit c_MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] r;
        logic [1:0] s;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [2:0] oper = 3'd0;
    logic [7:0] arg_a = 8'd0;
    logic [7:0] arg_b = 8'd0;
    logic       ready;
    logic       valid_out;
    logic [7:0] result;
    logic [1:0] status;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exe_unit_w2 #(.M(8)) dut (
        .i_clk    (clk),
        .i_rsn    (rst),
        .i_valid  (valid_in),
        .i_oper   (oper),
        .i_argA   (arg_a),
        .i_argB   (arg_b),
        .o_ready  (ready),
        .o_valid  (valid_out),
        .o_result (result),
        .o_status (status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model in plain integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic [1:0] s);
        int va, vb, v;
        bit ill, sat;
        va = $signed(a);
        vb = $signed(b);
        v = 0; ill = 0; sat = 0;
        case (op)
            3'd0: v = (va < vb) ? 127 : 0;
            3'd1: v = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
            3'd2: v = va + vb;
            3'd3: v = va - vb;
            3'd4: if (c_MUL_EN) v = va * vb; else ill = 1;
            default: ill = 1;
        endcase
        if (ill) begin
            r = 8'h00;
            s = 2'b11;
        end else begin
            if (v > 127) begin v = 127; sat = 1; end
            if (v < -128) begin v = -128; sat = 1; end
            r = v[7:0];
            s = sat ? 2'b10 : ((r == 8'h00) ? 2'b01 : 2'b00);
        end
    endfunction

    // Monitor: every o_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid cyc=%0d got result=%h status=%b, required no o_valid",
                         cyc, result, status);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (result !== e.r || status !== e.s || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL result_check got %h/%b at cyc %0d, required %h/%b at cyc %0d",
                             result, status, cyc, e.r, e.s, e.cyc);
                end
            end
        end
    end

    // Drives one request for one clock; queues the expectation if the
    // bench expects the unit to accept it.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit acc);
        exp_t e;
        valid_in = 1'b1;
        oper     = op;
        arg_a    = a;
        arg_b    = b;
        if (acc) begin
            model(op, a, b, e.r, e.s);
            e.cyc = cyc + 1 + ((op == 3'd4 && c_MUL_EN) ? 9 : 0);
            sb.push_back(e);
        end
        @(negedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        idle(2);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout pending=%0d, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        valid_in = 1'b1;
        oper     = OP_ADD;
        arg_a    = 8'd1;
        arg_b    = 8'd2;
        repeat (2) @(posedge clk);
        #1;
        n_vec += 3;
        if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b, required 0", valid_out); end
        if (result !== 8'h00) begin n_err++; $display("FAIL rst_result got %h, required 00", result); end
        if (status !== 2'b00) begin n_err++; $display("FAIL rst_status got %b, required 00", status); end
        @(negedge clk); #1;
        rst      = 1'b0;
        valid_in = 1'b0;
        @(posedge clk); #1;
        n_vec += 2;
        if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b, required 1", ready); end
        if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_post_valid got %b, required 0", valid_out); end
        @(negedge clk); #1;
    endtask

    task automatic test_cmp_sm2u2();
        issue(OP_CMP,   8'hFD, 8'h02, 1'b1);
        issue(OP_SM2U2, 8'h85, 8'h00, 1'b1);
        issue(OP_SM2U2, 8'h80, 8'h00, 1'b1);
        issue(OP_CMP,   8'h02, 8'hFD, 1'b1);
        issue(OP_SM2U2, 8'h05, 8'h00, 1'b1);
        issue(OP_CMP,   8'h80, 8'h7F, 1'b1);
        wait_drain();
    endtask

    task automatic test_add_sub();
        issue(OP_ADD, 8'd100, 8'd50, 1'b1);
        issue(OP_SUB, 8'h9C,  8'd50, 1'b1);
        issue(OP_ADD, 8'd5,   8'hFB, 1'b1);
        issue(OP_SUB, 8'd50,  8'h9C, 1'b1);
        issue(OP_ADD, 8'h80,  8'h80, 1'b1);
        issue(OP_SUB, 8'h80,  8'h01, 1'b1);
        for (int i = 0; i < 16; i++) begin
            issue(3'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'b1);
        end
        wait_drain();
    endtask

    task automatic test_mul();
        issue(OP_MUL, 8'd7,   8'hF7, 1'b1); wait_drain();
        issue(OP_MUL, 8'd12,  8'hF5, 1'b1); wait_drain();
        issue(OP_MUL, 8'h80,  8'h80, 1'b1); wait_drain();
        issue(OP_MUL, 8'h80,  8'h01, 1'b1); wait_drain();
        issue(OP_MUL, 8'h00,  8'h85, 1'b1); wait_drain();
        for (int i = 0; i < 4; i++) begin
            issue(OP_MUL, 8'($urandom), 8'($urandom), 1'b1);
            wait_drain();
        end
    endtask

    task automatic test_illegal();
        issue(3'b111, 8'h12, 8'h34, 1'b1);
        issue(3'b101, 8'h00, 8'h00, 1'b1);
        issue(3'b110, 8'hFF, 8'h01, 1'b1);
        wait_drain();
    endtask

    task automatic test_busy();
        bit exp_ready;
        issue(OP_MUL, 8'd3, 8'd4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            exp_ready = c_MUL_EN ? (i > 8) : 1'b1;
            n_vec++;
            if (ready !== exp_ready) begin
                n_err++;
                $display("FAIL busy_ready step %0d got %b, required %b", i, ready, exp_ready);
            end
            if (i == 3) issue(OP_ADD, 8'd1, 8'd1, !c_MUL_EN);
            else if (i < 9) idle(1);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_mul();
        issue(OP_MUL, 8'd7, 8'hF7, !c_MUL_EN);
        idle(3);
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec += 4;
        if (valid_out !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b, required 0", valid_out); end
        if (result !== 8'h00) begin n_err++; $display("FAIL midrst_result got %h, required 00", result); end
        if (status !== 2'b00) begin n_err++; $display("FAIL midrst_status got %b, required 00", status); end
        if (ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b, required 1", ready); end
        @(negedge clk); #1;
        rst = 1'b0;
        idle(12);
        issue(OP_ADD, 8'd1, 8'd2, 1'b1);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_cmp_sm2u2();
        test_add_sub();
        test_illegal();
        test_mul();
        test_busy();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
